regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised multi-port register file for the MIPS datapath, with an integrated pending-write scoreboard.
- Provides NUM_RD combinational read ports and one synchronous write port.
- Optional write-to-read bypass and optional hardwired zero register.
- Tracks registers with an outstanding producer in flight so the hazard unit can stall dependent instructions.
- Sits between decode (reads and issue) and writeback (write).

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 5: register index width; depth = 2**ADDR_W.
- NUM_RD, 2: number of read ports (1..4).
- ZERO_REG, 1: 1 = register 0 reads 0, ignores writes, and is never busy.
- BYPASS, 1: 1 = same-cycle write data forwarded to matching read ports.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- we  in  1  write enable (writeback stage).
- waddr  in  ADDR_W  write register index.
- wdata  in  DATA_W  write data.
- raddr  in  NUM_RD*ADDR_W  read indices; port i uses bits [i*ADDR_W +: ADDR_W].
- rdata  out  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  bit i = register at raddr port i has a pending write.
- issue_valid  in  1  an instruction with a destination register issues this cycle.
- issue_rd  in  ADDR_W  destination index of the issuing instruction.
- busy_cnt  out  ADDR_W+1  number of registers currently marked busy.
- dbg_addr  in  ADDR_W  debug read index.
- dbg_data  out  DATA_W  debug read data (never bypassed).

Behaviour:
- Reset: asynchronous assertion (rst_n=0), not gated by clk.
  - All storage cleared to 0; all busy bits cleared; busy_cnt=0.
  - Outputs during reset: rdata=0, dbg_data=0, rd_busy=0.
- Write: on posedge clk, if we=1 and not (ZERO_REG=1 and waddr==0), mem[waddr] <= wdata.
- Read: combinational, zero latency.
  - rdata_i = 0 if ZERO_REG=1 and raddr_i==0.
  - Else rdata_i = wdata if BYPASS=1, we=1 and waddr==raddr_i.
  - Else rdata_i = mem[raddr_i].
  - With BYPASS=0, a read of the register being written returns the old value this cycle and the new value the next cycle.
  - Multiple ports reading the same index return identical data.
- Scoreboard: one busy bit per register, updated on posedge clk.
  - Set: issue_valid=1 and issue_rd nonzero (or any index when ZERO_REG=0) → busy[issue_rd] <= 1.
  - Clear: we=1 → busy[waddr] <= 0.
  - Same index set and cleared in one cycle: set wins (the newer producer is still outstanding).
  - Different indices: both updates take effect.
  - Setting an already-busy bit: no change, no error.
  - Clearing a non-busy bit: no change.
- rd_busy_i = busy[raddr_i] and not (we=1 and waddr==raddr_i and BYPASS=1).
  - A bypassed writeback resolves the hazard in the same cycle.
  - With BYPASS=0, rd_busy_i follows busy[raddr_i] directly.
  - Always 0 for index 0 when ZERO_REG=1.
- busy_cnt: registered; equals the popcount of the busy vector after each edge.
  - Range 0..2**ADDR_W; ADDR_W+1 bits, so no overflow.
  - Update per cycle: +1, −1, or 0, derived from the actual bit transitions, not from raw strobes.
- All storage is flop-based (no memory inference requirement).
- No X propagation from uninitialised state, because of reset.

Test Plan:
- Reset: assert rst_n=0 mid-run after writing r5=0xDEADBEEF and issuing r7 → r5 reads 0, rd_busy=0, busy_cnt=0 immediately, before any clk edge.
- Write/read: we=1, waddr=3, wdata=0x12345678, raddr0=3.
  - BYPASS=1: rdata0=0x12345678 in the same cycle.
  - BYPASS=0: rdata0 is the old value in that cycle and 0x12345678 after the edge.
- Zero register: write r0=0xFFFFFFFF, then read r0 on both ports → 0. issue_rd=0 → busy_cnt stays 0.
- Scoreboard: issue r8 (cycle 1) → rd_busy for raddr=8 is 1 and busy_cnt=1. Writeback r8 in cycle 4 with BYPASS=1 → rd_busy=0 in cycle 4 and busy_cnt=0 after the edge.
- Simultaneous set/clear: we=1, waddr=9 and issue_valid=1, issue_rd=9 on one edge → busy[9] stays 1 and busy_cnt unchanged. Different indices 9 and 10 on one edge → busy[9]=0, busy[10]=1.
- Parameter sweep: DATA_W=16, ADDR_W=3, NUM_RD=3, ZERO_REG=0.
  - Issue all 8 registers → busy_cnt=8.
  - Write r0=0xABCD → reads 0xABCD on all three ports.
  - Random write/read traffic matches a reference model.

Source files
------------

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass, optional zero register,
// and a pending-write scoreboard that feeds the hazard unit.

module regfile_sb_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                                i_rst_n,
  input  logic                                i_we,
  input  logic [ADDR_W-1:0]                   i_waddr,
  input  logic [DATA_W-1:0]                   i_wdata,
  input  logic [ADDR_W-1:0]                   i_raddr,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]    i_mem,
  input  logic [2**ADDR_W-1:0]                i_busy,
  output logic [DATA_W-1:0]                   o_rdata,
  output logic                                o_rd_busy
);
  logic w_zero, w_byp;

  assign w_zero = (ZERO_REG != 0) && (i_raddr == '0);
  assign w_byp  = (BYPASS != 0) && i_we && (i_waddr == i_raddr);

  // A bypassed writeback also resolves the hazard in the same cycle.
  always_comb begin
    o_rdata   = i_mem[i_raddr];
    o_rd_busy = i_busy[i_raddr];
    if (w_byp) begin
      o_rdata   = i_wdata;
      o_rd_busy = 1'b0;
    end
    if (w_zero || !i_rst_n) begin
      o_rdata   = '0;
      o_rd_busy = 1'b0;
    end
  end
endmodule

module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_rd,
  output logic [ADDR_W:0]          busy_cnt,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_W-1:0]        dbg_data
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0] r_mem;
  logic [DEPTH-1:0]             r_busy;
  logic [ADDR_W:0]              r_busy_cnt;

  logic w_wr_ok, w_set_ok, w_set_eff, w_clr_eff;

  assign w_wr_ok  = we && !((ZERO_REG != 0) && (waddr == '0));
  assign w_set_ok = issue_valid && !((ZERO_REG != 0) && (issue_rd == '0));
  // Count real bit flips only: re-setting a busy bit or clearing an idle one is a no-op,
  // and a clear on the index being re-issued loses to the set.
  assign w_set_eff = w_set_ok && !r_busy[issue_rd];
  assign w_clr_eff = we && r_busy[waddr] && !(w_set_ok && (issue_rd == waddr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem      <= '0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wr_ok) r_mem[waddr] <= wdata;
      if (we) r_busy[waddr] <= 1'b0;
      if (w_set_ok) r_busy[issue_rd] <= 1'b1;
      r_busy_cnt <= r_busy_cnt + {{ADDR_W{1'b0}}, w_set_eff} - {{ADDR_W{1'b0}}, w_clr_eff};
    end
  end

  assign busy_cnt = r_busy_cnt;
  assign dbg_data = r_mem[dbg_addr];

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_sb_rdport #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
    ) u_rd (
      .i_rst_n  (rst_n),
      .i_we     (we),
      .i_waddr  (waddr),
      .i_wdata  (wdata),
      .i_raddr  (raddr[g*ADDR_W +: ADDR_W]),
      .i_mem    (r_mem),
      .i_busy   (r_busy),
      .o_rdata  (rdata[g*DATA_W +: DATA_W]),
      .o_rd_busy(rd_busy[g])
    );
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed and random checks of regfile_sb: default config, no-bypass config,
// and a narrow 3-port config without a zero register.

module tb_regfile_sb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // shared stimulus for the two 32x32 instances
  logic        we, issue_valid;
  logic [4:0]  waddr, issue_rd, dbg_addr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata_a, rdata_b;
  logic [1:0]  rd_busy_a, rd_busy_b;
  logic [5:0]  busy_cnt_a, busy_cnt_b;
  logic [31:0] dbg_a, dbg_b;

  // narrow instance
  logic        we_c, issue_valid_c;
  logic [2:0]  waddr_c, issue_rd_c, dbg_addr_c;
  logic [15:0] wdata_c;
  logic [8:0]  raddr_c;
  logic [47:0] rdata_c;
  logic [2:0]  rd_busy_c;
  logic [3:0]  busy_cnt_c;
  logic [15:0] dbg_c;

  regfile_sb dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_a), .rd_busy(rd_busy_a), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy_cnt(busy_cnt_a), .dbg_addr(dbg_addr), .dbg_data(dbg_a));

  regfile_sb #(.BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .rd_busy(rd_busy_b), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy_cnt(busy_cnt_b), .dbg_addr(dbg_addr), .dbg_data(dbg_b));

  regfile_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .we(we_c), .waddr(waddr_c), .wdata(wdata_c), .raddr(raddr_c),
    .rdata(rdata_c), .rd_busy(rd_busy_c), .issue_valid(issue_valid_c), .issue_rd(issue_rd_c),
    .busy_cnt(busy_cnt_c), .dbg_addr(dbg_addr_c), .dbg_data(dbg_c));

  typedef struct {
    string       tag;
    logic [63:0] v;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nfail = 0;

  task automatic push(input string t, input logic [63:0] v);
    exp_t e;
    e.tag = t;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    ncmp++;
    if (sb.size() == 0) begin
      nfail++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        nfail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference state for the random phase of the narrow instance
  logic [15:0] mem_m [8];
  logic [7:0]  busy_m;
  logic [2:0]  ra;
  int          pc;

  initial begin
    rst_n = 1'b0;
    we = 0; issue_valid = 0; waddr = '0; issue_rd = '0; dbg_addr = '0; wdata = '0; raddr = '0;
    we_c = 0; issue_valid_c = 0; waddr_c = '0; issue_rd_c = '0; dbg_addr_c = '0;
    wdata_c = '0; raddr_c = '0;
    #2;
    push("rst_cnt_a", 0);   chk(busy_cnt_a);
    push("rst_rdata_a", 0); chk(rdata_a);
    push("rst_cnt_c", 0);   chk(busy_cnt_c);
    tick(); tick();
    rst_n = 1'b1;

    // write r3 with read on port 0
    we = 1; waddr = 5'd3; wdata = 32'h12345678; raddr = {5'd0, 5'd3}; dbg_addr = 5'd3;
    #1;
    push("byp_rd0_a", 32'h12345678); chk(rdata_a[31:0]);
    push("nobyp_old_b", 0);          chk(rdata_b[31:0]);
    push("dbg_nobyp_a", 0);          chk(dbg_a);
    tick();
    we = 0;
    #1;
    push("rd0_after_a", 32'h12345678); chk(rdata_a[31:0]);
    push("rd0_after_b", 32'h12345678); chk(rdata_b[31:0]);
    push("dbg_after_a", 32'h12345678); chk(dbg_a);

    // zero register
    we = 1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr = {5'd0, 5'd0};
    #1;
    push("zero_byp_a", 0); chk(rdata_a);
    tick();
    we = 0;
    #1;
    push("zero_rd_a", 0); chk(rdata_a);
    push("zero_rd_b", 0); chk(rdata_b);
    issue_valid = 1; issue_rd = 5'd0;
    tick();
    issue_valid = 0;
    #1;
    push("zero_issue_cnt", 0); chk(busy_cnt_a);
    push("zero_busy", 0);      chk(rd_busy_a);

    // scoreboard: issue r8, write it back three cycles later
    issue_valid = 1; issue_rd = 5'd8;
    tick();
    issue_valid = 0; raddr = {5'd0, 5'd8};
    #1;
    push("sb_busy_a", 1); chk(rd_busy_a[0]);
    push("sb_cnt_a", 1);  chk(busy_cnt_a);
    tick(); tick();
    we = 1; waddr = 5'd8; wdata = 32'h0000CAFE;
    #1;
    push("sb_wb_busy_a", 0); chk(rd_busy_a[0]);
    push("sb_wb_busy_b", 1); chk(rd_busy_b[0]);
    tick();
    we = 0;
    #1;
    push("sb_cnt_after_a", 0);  chk(busy_cnt_a);
    push("sb_cnt_after_b", 0);  chk(busy_cnt_b);
    push("sb_busy_after_b", 0); chk(rd_busy_b[0]);

    // set/clear collisions
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    we = 1; waddr = 5'd9; issue_rd = 5'd9;
    tick();
    we = 0; issue_valid = 0; raddr = {5'd10, 5'd9};
    #1;
    push("same_busy9", 2'b01); chk(rd_busy_a);
    push("same_cnt", 1);       chk(busy_cnt_a);
    we = 1; waddr = 5'd9; issue_valid = 1; issue_rd = 5'd10;
    tick();
    we = 0; issue_valid = 0;
    #1;
    push("diff_busy", 2'b10); chk(rd_busy_a);
    push("diff_cnt", 1);      chk(busy_cnt_a);
    we = 1; waddr = 5'd11; issue_valid = 1; issue_rd = 5'd10;
    tick();
    we = 0; issue_valid = 0;
    #1;
    push("noop_cnt", 1); chk(busy_cnt_a);

    // asynchronous reset mid-run
    we = 1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick();
    we = 0; issue_valid = 1; issue_rd = 5'd7;
    tick();
    issue_valid = 0; raddr = {5'd7, 5'd5};
    #1;
    push("pre_rst_rd", 32'hDEADBEEF); chk(rdata_a[31:0]);
    push("pre_rst_busy", 2'b10);      chk(rd_busy_a);
    push("pre_rst_cnt", 2);           chk(busy_cnt_a);
    rst_n = 1'b0;
    #1;
    push("async_rst_rd", 0);   chk(rdata_a[31:0]);
    push("async_rst_busy", 0); chk(rd_busy_a);
    push("async_rst_cnt", 0);  chk(busy_cnt_a);
    tick();
    rst_n = 1'b1;
    #1;
    push("post_rst_rd", 0); chk(rdata_a[31:0]);

    // narrow instance: fill scoreboard, then write r0
    for (int r = 0; r < 8; r++) begin
      issue_valid_c = 1; issue_rd_c = 3'(r);
      tick();
    end
    issue_valid_c = 0;
    #1;
    push("c_cnt_full", 8); chk(busy_cnt_c);
    we_c = 1; waddr_c = 3'd0; wdata_c = 16'hABCD; raddr_c = '0;
    #1;
    push("c_r0_byp", 16'hABCD); chk(rdata_c[15:0]);
    tick();
    we_c = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("c_r0_p%0d", i), 16'hABCD); chk(rdata_c[i*16 +: 16]);
    end
    push("c_cnt_r0", 7); chk(busy_cnt_c);

    for (int i = 0; i < 8; i++) mem_m[i] = '0;
    mem_m[0] = 16'hABCD;
    busy_m = 8'hFE;

    // random traffic against the reference model
    for (int n = 0; n < 60; n++) begin
      we_c          = 1'($urandom_range(0, 1));
      waddr_c       = 3'($urandom_range(0, 7));
      wdata_c       = 16'($urandom);
      issue_valid_c = 1'($urandom_range(0, 1));
      issue_rd_c    = 3'($urandom_range(0, 7));
      raddr_c       = 9'($urandom);
      dbg_addr_c    = 3'($urandom_range(0, 7));
      #1;
      for (int i = 0; i < 3; i++) begin
        ra = raddr_c[i*3 +: 3];
        push($sformatf("c_rnd%0d_rd%0d", n, i), (we_c && waddr_c == ra) ? wdata_c : mem_m[ra]);
        chk(rdata_c[i*16 +: 16]);
        push($sformatf("c_rnd%0d_bz%0d", n, i), busy_m[ra] && !(we_c && waddr_c == ra));
        chk(rd_busy_c[i]);
      end
      push($sformatf("c_rnd%0d_dbg", n), mem_m[dbg_addr_c]); chk(dbg_c);
      if (we_c) begin
        mem_m[waddr_c] = wdata_c;
        busy_m[waddr_c] = 1'b0;
      end
      if (issue_valid_c) busy_m[issue_rd_c] = 1'b1;
      pc = 0;
      for (int i = 0; i < 8; i++) pc += int'(busy_m[i]);
      tick();
      push($sformatf("c_rnd%0d_cnt", n), pc); chk(busy_cnt_c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
